// File: rtl/mul16_sequencer.sv
// Multi-cycle 16x16 (or 8x8) unsigned multiply sequencer driving an external
// combinational 8x8 multiplier one byte pair per cycle and accumulating into 32 bits.
module mul16_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_8bit,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        mode_r;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] product_r;
    logic        accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = product_r;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mul_a     = 8'h00;
        mul_b     = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PP0;
                    acc_nxt   = 32'h0;
                end
            end
            PP0: begin
                mul_a     = a_r[7:0];
                mul_b     = b_r[7:0];
                acc_nxt   = {16'h0000, mul_p};
                state_nxt = mode_r ? DONE : PP1;
            end
            // Both cross terms carry a weight of 2^8.
            PP1: begin
                mul_a     = a_r[15:8];
                mul_b     = b_r[7:0];
                acc_nxt   = acc + {8'h00, mul_p, 8'h00};
                state_nxt = PP2;
            end
            PP2: begin
                mul_a     = a_r[7:0];
                mul_b     = b_r[15:8];
                acc_nxt   = acc + {8'h00, mul_p, 8'h00};
                state_nxt = PP3;
            end
            PP3: begin
                mul_a     = a_r[15:8];
                mul_b     = b_r[15:8];
                acc_nxt   = acc + {mul_p, 16'h0000};
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The result register only loads on entry to DONE, so product stays
    // stable through the handshake and keeps its value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= 16'h0000;
            b_r       <= 16'h0000;
            mode_r    <= 1'b0;
            acc       <= 32'h0;
            product_r <= 32'h0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            if (accept) begin
                a_r    <= op_a;
                b_r    <= op_b;
                mode_r <= op_8bit;
            end
            if ((state != DONE) && (state_nxt == DONE)) begin
                product_r <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mul16_sequencer.sv
// Bench for mul16_sequencer: behavioural transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul16_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_8bit;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int vectors;
    int miscompares;
    bit checking;

    // Behavioural model: step 0 idle, 1..m_n byte pairs, m_n+1 result waiting.
    int          m_step;
    int          m_n;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [31:0] m_last;
    int          cyc;
    int          accepts[$];
    logic [15:0] seen[$];

    mul16_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_8bit   (op_8bit),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Stand-in for the combinational Wallace multiplier.
    assign mul_p = {8'h00, mul_a} * {8'h00, mul_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_step <= 0;
            m_last <= 32'h0;
        end else if (m_step == 0) begin
            if (in_valid) begin
                m_a    <= op_8bit ? {8'h00, op_a[7:0]} : op_a;
                m_b    <= op_8bit ? {8'h00, op_b[7:0]} : op_b;
                m_n    <= op_8bit ? 1 : 4;
                m_step <= 1;
                accepts.push_back(cyc);
            end
        end else if (m_step <= m_n) begin
            m_step <= m_step + 1;
        end else if (out_ready) begin
            m_last <= {16'h0000, m_a} * {16'h0000, m_b};
            m_step <= 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            automatic bit         idle = (m_step == 0);
            automatic bit         done = (m_step != 0) && (m_step > m_n);
            automatic int         idx  = m_step - 1;
            automatic logic [7:0] ea   = 8'h00;
            automatic logic [7:0] eb   = 8'h00;
            if (!idle && !done) begin
                ea = ((idx & 1) != 0) ? m_a[15:8] : m_a[7:0];
                eb = ((idx & 2) != 0) ? m_b[15:8] : m_b[7:0];
            end
            check_output("in_ready", 32'(in_ready), 32'(idle && !rst));
            check_output("busy", 32'(busy), 32'(!idle));
            check_output("out_valid", 32'(out_valid), 32'(done));
            check_output("mul_a", 32'(mul_a), 32'(ea));
            check_output("mul_b", 32'(mul_b), 32'(eb));
            if (done) begin
                check_output("product", product, {16'h0000, m_a} * {16'h0000, m_b});
            end else if (idle) begin
                check_output("product_hold", product, m_last);
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("accept_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        seen.delete();
        do begin
            @(negedge clk);
            lat++;
            seen.push_back({mul_a, mul_b});
        end while (!out_valid && lat < 50);
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic m,
                                  input logic [31:0] want, input int stall);
        int lat;
        @(posedge clk);
        #1;
        op_a      = a;
        op_b      = b;
        op_8bit   = m;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        wait_accept();
        in_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        op_8bit  = 1'($urandom);
        wait_out_valid(lat);
        check_output("latency", 32'(lat), m ? 32'd2 : 32'd5);
        check_output("product_lit", product, want);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            @(negedge clk);
            check_output("stall_valid", 32'(out_valid), 32'h1);
            check_output("stall_product", product, want);
        end
        if (stall > 0) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_output("post_ready", 32'(in_ready), 32'h1);
        check_output("post_valid", 32'(out_valid), 32'h0);
        check_output("post_product", product, want);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        checking    = 1'b0;
        cyc         = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        op_a        = 16'h0;
        op_b        = 16'h0;
        op_8bit     = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check_output("rst_product", product, 32'h0);
        check_output("rst_valid", 32'(out_valid), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_ready", 32'(in_ready), 32'h1);
        check_output("rst_mul", {16'h0, mul_a, mul_b}, 32'h0);

        $display("[TB] basic 16-bit op");
        apply_stimulus(16'h1234, 16'h5678, 1'b0, 32'h06260060, 0);
        check_output("seq0", 32'(seen[0]), 32'h3478);
        check_output("seq1", 32'(seen[1]), 32'h1278);
        check_output("seq2", 32'(seen[2]), 32'h3456);
        check_output("seq3", 32'(seen[3]), 32'h1256);

        $display("[TB] max operands");
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);

        $display("[TB] 8-bit op");
        apply_stimulus(16'hAB12, 16'hCD34, 1'b1, 32'h000003A8, 0);
        check_output("seq8", 32'(seen[0]), 32'h1234);

        $display("[TB] backpressure");
        apply_stimulus(16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 10);

        $display("[TB] reset during PP2");
        @(posedge clk);
        #1;
        op_a     = 16'h1234;
        op_b     = 16'h5678;
        op_8bit  = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("pp2_pair", {16'h0, mul_a, mul_b}, 32'h3456);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_valid", 32'(out_valid), 32'h0);
        check_output("abort_busy", 32'(busy), 32'h0);
        check_output("abort_ready", 32'(in_ready), 32'h1);
        check_output("abort_mul", {16'h0, mul_a, mul_b}, 32'h0);
        apply_stimulus(16'h0003, 16'h0004, 1'b0, 32'h0000000C, 0);

        $display("[TB] back-to-back with in_valid held");
        @(posedge clk);
        #1;
        op_a     = 16'h0000;
        op_b     = 16'hBEEF;
        op_8bit  = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        op_a = 16'h8000;
        op_b = 16'h0002;
        wait_out_valid(lat);
        check_output("b2b_first", product, 32'h00000000);
        wait_accept();
        in_valid = 1'b0;
        wait_out_valid(lat);
        check_output("b2b_second", product, 32'h00010000);
        check_output("b2b_spacing", 32'(accepts[accepts.size()-1] - accepts[accepts.size()-2]), 32'd6);
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            op_8bit   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
